sram_arbiter: RTL
=================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter BURST_X, default 8, words per X-load burst.
REQ-002 SHALL have parameter BURST_A, default 32, words per A-load burst.
REQ-003 SHALL have parameter BURST_W, default 4, words per result-write burst.
REQ-004 SHALL have parameters BASE_X, BASE_A, BASE_W, defaults 0, 16, 64, start addresses of each region.
REQ-005 SHALL have parameters DATA_W, default 16, and ADDR_W, default 7.
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 req  input  3  request lines: bit0 X loader (read), bit1 A loader (read), bit2 result writer (write).
REQ-010 w_data  input  DATA_W  write data from the result writer, sampled on each write beat.
REQ-011 sram_rdata  input  DATA_W  SRAM read data, valid one cycle after a read beat.
REQ-012 gnt  output  3  one-hot grant, held for the whole burst.
REQ-013 sram_en  output  1  SRAM access strobe, one per beat.
REQ-014 sram_we  output  1  high on write beats.
REQ-015 sram_addr  output  ADDR_W  beat address.
REQ-016 sram_wdata  output  DATA_W  equals w_data.
REQ-017 rd_valid  output  1  sram_rdata is valid for the requester granted one cycle earlier.
REQ-018 beat_idx  output  6  index of the current beat within the burst.
REQ-019 burst_done  output  1  one-cycle pulse after the last beat and its read data, if any, complete.

Function
REQ-020 SHALL implement the states IDLE, BURST and DRAIN.
REQ-021 IDLE: if any req bit is high, SHALL pick a winner and enter BURST on the next cycle, with gnt set one-hot to that winner.
- The result writer (bit2) wins whenever it requests.
- Otherwise X and A alternate round-robin; the loser of the last X/A arbitration has priority. After reset X has priority.
REQ-022 BURST: SHALL assert sram_en every cycle and present sram_addr = base + offset + beat_idx, with beat_idx running 0 to BURST_n-1.
REQ-023 BURST: sram_we SHALL equal gnt[2].
REQ-024 After the last beat, a read burst SHALL enter DRAIN; a write burst SHALL return to IDLE with a burst_done pulse.
REQ-025 DRAIN: SHALL last one cycle, pulse burst_done, then return to IDLE; no new arbitration takes place in DRAIN.
REQ-026 rd_valid SHALL be sram_en and not sram_we, delayed by one cycle.
REQ-027 Offset SHALL be 0 for X and A bursts.
REQ-028 Offset for W bursts SHALL be col*BURST_W, where col is a 2-bit column counter.
- col increments at the end of each W burst and wraps from 3 to 0.
- The four W bursts fill 16 consecutive words.
REQ-029 Deasserting req mid-burst SHALL be ignored; the burst always completes.
REQ-030 A req held continuously SHALL be re-arbitrated in IDLE after each burst.
REQ-031 The minimum gap between bursts SHALL be one IDLE cycle.
REQ-032 Simultaneous requests on all three lines SHALL be served in the order W, then X/A round-robin; no requester waits longer than two foreign bursts.
REQ-033 gnt, sram_en, sram_we and sram_addr SHALL be registered outputs.

Reset
REQ-034 While rst is high at a clock edge:
- state goes to IDLE;
- gnt, sram_en, sram_we, sram_addr, rd_valid, beat_idx and burst_done go to 0;
- col goes to 0 and the round-robin pointer goes to X.
REQ-035 Reset asserted mid-burst SHALL abort the burst with no burst_done pulse; the aborted burst is lost.

Structure
REQ-036 A shared package SHALL hold the state encoding (IDLE=2'b00, BURST=2'b01, DRAIN=2'b10), the requester index constants (REQ_X=0, REQ_A=1, REQ_W=2) and the default burst and base constants.
REQ-037 SHALL contain one sub-module, rr_pick2, a two-input round-robin selector with a priority-pointer register.

Verification
REQ-038 Bench SHALL cover the following scenarios:
- req=001 held one cycle -> gnt=001 next cycle; 8 reads at addresses 0..7; rd_valid on cycles 2..9; burst_done in DRAIN.
- req=011 held -> bursts alternate X, A, X; the A burst covers addresses 16..47.
- req=111 at once -> W burst first (addresses 64..67, sram_we=1), then X, then A.
- Four W bursts -> addresses 64..79; the fifth W burst wraps to 64.
- req dropped at beat 3 of an A burst -> all 32 beats still issued; burst_done pulses.
- rst at beat 5 of an X burst -> all outputs 0 next cycle; no burst_done; the next req=010 is served from address 16.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the SRAM burst arbiter.
package sram_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BURST = 2'b01,
        DRAIN = 2'b10
    } state_e;

    localparam int REQ_X = 0;
    localparam int REQ_A = 1;
    localparam int REQ_W = 2;

    localparam int DEF_BURST_X = 8;
    localparam int DEF_BURST_A = 32;
    localparam int DEF_BURST_W = 4;
    localparam int DEF_BASE_X  = 0;
    localparam int DEF_BASE_A  = 16;
    localparam int DEF_BASE_W  = 64;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_ADDR_W  = 7;
    localparam int BEAT_W      = 6;

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester/SRAM bundle; slave is the arbiter side, master the surrounding logic.
interface sram_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 7
);
    logic [2:0]        req;
    logic [DATA_W-1:0] w_data;
    logic [DATA_W-1:0] sram_rdata;
    logic [2:0]        gnt;
    logic              sram_en;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic              rd_valid;
    logic [5:0]        beat_idx;
    logic              burst_done;

    modport slave (
        input  req, w_data, sram_rdata,
        output gnt, sram_en, sram_we, sram_addr, sram_wdata, rd_valid, beat_idx, burst_done
    );

    modport master (
        output req, w_data, sram_rdata,
        input  gnt, sram_en, sram_we, sram_addr, sram_wdata, rd_valid, beat_idx, burst_done
    );
endinterface

// File: rtl/sram_arbiter_rr_pick2.sv
// Two-input round-robin selector; the pointer favours whoever lost the last pick.
module rr_pick2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       adv,
    output logic [1:0] pick
);
    // prio_q = 0: input 0 has priority, 1: input 1 has priority
    logic prio_q, prio_d;

    always_comb begin
        pick   = 2'b00;
        prio_d = prio_q;
        if (req[0] && (!prio_q || !req[1]))
            pick = 2'b01;
        else if (req[1])
            pick = 2'b10;
        if (adv && (pick != 2'b00))
            prio_d = pick[0];
    end

    always_ff @(posedge clk) begin
        if (rst) prio_q <= 1'b0;
        else     prio_q <= prio_d;
    end
endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates X/A read bursts and result-write bursts onto one single-port SRAM.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int BURST_X = DEF_BURST_X,
    parameter int BURST_A = DEF_BURST_A,
    parameter int BURST_W = DEF_BURST_W,
    parameter int BASE_X  = DEF_BASE_X,
    parameter int BASE_A  = DEF_BASE_A,
    parameter int BASE_W  = DEF_BASE_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W
) (
    input  logic          clk,
    input  logic          rst,
    sram_arbiter_if.slave bus
);
    state_e              state_q, state_d;
    logic [2:0]          gnt_q, gnt_d;
    logic                en_q, en_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                rdv_q, rdv_d;
    logic                done_q, done_d;
    logic [1:0]          col_q, col_d;

    logic [1:0]          rr_pick;
    logic                rr_adv;
    logic [2:0]          win;
    logic [ADDR_W-1:0]   start_addr;
    logic [BEAT_W-1:0]   last_beat;

    rr_pick2 u_rr (
        .clk  (clk),
        .rst  (rst),
        .req  (bus.req[REQ_A:REQ_X]),
        .adv  (rr_adv),
        .pick (rr_pick)
    );

    // The writer always pre-empts the X/A round-robin
    assign win = bus.req[REQ_W] ? 3'b100 : {1'b0, rr_pick};

    always_comb begin
        case (win)
            3'b100:  start_addr = ADDR_W'(BASE_W + int'(col_q) * BURST_W);
            3'b010:  start_addr = ADDR_W'(BASE_A);
            default: start_addr = ADDR_W'(BASE_X);
        endcase
        case (gnt_q)
            3'b100:  last_beat = BEAT_W'(BURST_W - 1);
            3'b010:  last_beat = BEAT_W'(BURST_A - 1);
            default: last_beat = BEAT_W'(BURST_X - 1);
        endcase
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        en_d    = 1'b0;
        we_d    = 1'b0;
        addr_d  = addr_q;
        beat_d  = beat_q;
        done_d  = 1'b0;
        col_d   = col_q;
        rr_adv  = 1'b0;
        rdv_d   = en_q & ~we_q;
        case (state_q)
            IDLE: begin
                gnt_d  = 3'b000;
                beat_d = '0;
                if (|bus.req) begin
                    state_d = BURST;
                    gnt_d   = win;
                    en_d    = 1'b1;
                    we_d    = win[REQ_W];
                    addr_d  = start_addr;
                    rr_adv  = ~bus.req[REQ_W];
                end
            end
            BURST: begin
                if (beat_q == last_beat) begin
                    done_d = 1'b1;
                    addr_d = '0;
                    beat_d = '0;
                    // Reads wait one more cycle for the final read data
                    if (gnt_q[REQ_W]) begin
                        state_d = IDLE;
                        gnt_d   = 3'b000;
                        col_d   = col_q + 2'd1;
                    end else begin
                        state_d = DRAIN;
                    end
                end else begin
                    en_d   = 1'b1;
                    we_d   = we_q;
                    addr_d = addr_q + ADDR_W'(1);
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            DRAIN: begin
                state_d = IDLE;
                gnt_d   = 3'b000;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 3'b000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 3'b000;
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            beat_q  <= '0;
            rdv_q   <= 1'b0;
            done_q  <= 1'b0;
            col_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            en_q    <= en_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            beat_q  <= beat_d;
            rdv_q   <= rdv_d;
            done_q  <= done_d;
            col_q   <= col_d;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.sram_en    = en_q;
    assign bus.sram_we    = we_q;
    assign bus.sram_addr  = addr_q;
    assign bus.sram_wdata = bus.w_data;
    assign bus.rd_valid   = rdv_q;
    assign bus.beat_idx   = beat_q;
    assign bus.burst_done = done_q;
endmodule
